mem_port_arbiter: RTL and testbench

Shares the single-port program/data memory of the accumulator CPU between the CPU sequence controller (instruction fetch, operand read, store) and a DMA/loader port used for program load and debug access. The block arbitrates round-robin, drives the memory's enable/write/address/data pins, waits a fixed read latency and returns read data with a one-cycle done pulse. It sits between the controller/datapath bus and the memory macro.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter between the CPU sequence controller
// and the DMA/loader port for one single-port memory. It issues one memory
// access at a time, waits a fixed read latency and returns read data to the
// serviced port together with a one-cycle done pulse.
module mem_port_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int MEM_LAT = 2   // cycles from a read's mem_en until mem_rdata is valid, 1..15
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,

  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [DW-1:0] dma_rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Value of the wait counter in the last WAIT cycle.
  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

  state_t        state;
  logic          last_dma;   // 1: the most recent grant went to the DMA port
  logic          cur_dma;    // port being serviced by the access in flight
  logic          cur_we;     // access in flight is a write
  logic [3:0]    cnt;        // read latency counter

  logic          any_req;
  logic          pick_dma;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  // Round-robin winner selection and the winner's request fields.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch can be inferred.
    any_req   = cpu_req | dma_req;
    pick_dma  = dma_req;
    if (cpu_req && dma_req) begin
      pick_dma = ~last_dma;
    end
    win_we    = cpu_we;
    win_addr  = cpu_addr;
    win_wdata = cpu_wdata;
    if (pick_dma) begin
      win_we    = dma_we;
      win_addr  = dma_addr;
      win_wdata = dma_wdata;
    end
  end

  // Access sequencer: all outputs are registered, pulses default low each cycle.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before this edge, independent of statement order.
    if (rst) begin
      // NOTE: the rdata holding registers are plain flops and are cleared on
      // reset along with the rest; an abandoned access leaves nothing behind.
      state     <= IDLE;
      last_dma  <= 1'b1;
      cur_dma   <= 1'b0;
      cur_we    <= 1'b0;
      cnt       <= '0;
      cpu_gnt   <= 1'b0;
      dma_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      cpu_gnt   <= 1'b0;
      dma_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;

      unique case (state)
        IDLE, RESP: begin
          if (any_req) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            cur_dma   <= pick_dma;
            cur_we    <= win_we;
            last_dma  <= pick_dma;
            cpu_gnt   <= ~pick_dma;
            dma_gnt   <= pick_dma;
            mem_en    <= 1'b1;
            mem_we    <= win_we;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        ISSUE: begin
          if (cur_we) begin
            state    <= RESP;
            cpu_done <= ~cur_dma;
            dma_done <= cur_dma;
          end else begin
            state <= WAIT;
            cnt   <= '0;
          end
        end

        WAIT: begin
          if (cnt == CNT_LAST) begin
            state    <= RESP;
            cnt      <= '0;
            cpu_done <= ~cur_dma;
            dma_done <= cur_dma;
            if (cur_dma) begin
              dma_rdata <= mem_rdata;
            end else begin
              cpu_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed requester scenarios feed an
// expectation queue; an independent monitor checks every memory issue and
// every done pulse against it, including timing and read data routing.
module tb_mem_port_arbiter;

  localparam int AW      = 5;
  localparam int DW      = 8;
  localparam int MEM_LAT = 2;
  localparam int TIMEOUT = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  int            cyc = 0;

  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_done;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_gnt, dma_done;
  logic [DW-1:0] dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Clock; cyc numbers the cycle that starts at each rising edge.
  initial begin
    forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Memory model: preloaded contents, writes on mem_en&mem_we, read data
  // presented exactly MEM_LAT cycles after the read's mem_en cycle.
  logic [DW-1:0] mem     [32];
  logic [DW-1:0] rd_pipe [MEM_LAT];
  bit            mem_loaded;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      mem[5'h0A] <= 8'h5C;
      mem[5'h01] <= 8'hC1;
      mem[5'h02] <= 8'hC2;
      mem[5'h03] <= 8'hC3;
      mem[5'h04] <= 8'hC4;
      mem[5'h11] <= 8'hD1;
      mem[5'h12] <= 8'hD2;
      mem[5'h13] <= 8'hD3;
      mem[5'h14] <= 8'hD4;
      mem_loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 8'h00;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[MEM_LAT-1];

  // Scoreboard state.
  typedef struct {
    int            port;     // 0 = CPU, 1 = DMA
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;    // expected read data (reads only)
    int            gnt_cyc;  // expected grant cycle, -1 = directly after previous done
  } exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } stim_t;

  exp_t          exp_q[$];
  stim_t         cpu_stim[$];
  stim_t         dma_stim[$];
  exp_t          cur;
  bit            cur_v = 1'b0;
  int            cur_gnt_at = 0;
  int            last_done_at = -100;
  logic [DW-1:0] model_rd [2] = '{8'h00, 8'h00};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every issue and every done against the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (mem_en) begin
      check("expectation pending at issue", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("cpu_gnt at issue", 32'(cpu_gnt), 32'(e.port == 0));
        check("dma_gnt at issue", 32'(dma_gnt), 32'(e.port == 1));
        check("mem_we", 32'(mem_we), 32'(e.we));
        check("mem_addr", 32'(mem_addr), 32'(e.addr));
        check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
        check("busy at issue", 32'(busy), 32'd1);
        check("issue overlaps access", 32'(cur_v), 32'd0);
        if (e.gnt_cyc < 0) check("back-to-back issue cycle", 32'(cyc), 32'(last_done_at + 1));
        else               check("issue cycle", 32'(cyc), 32'(e.gnt_cyc));
        cur        = e;
        cur_v      = 1'b1;
        cur_gnt_at = cyc;
      end
    end else begin
      check("idle memory bus and grants",
            32'({cpu_gnt, dma_gnt, mem_we, mem_addr, mem_wdata}), 32'd0);
    end

    if (cpu_done || dma_done) begin
      check("done with access in flight", 32'(cur_v), 32'd1);
      if (cur_v) begin
        check("cpu_done", 32'(cpu_done), 32'(cur.port == 0));
        check("dma_done", 32'(dma_done), 32'(cur.port == 1));
        check("done latency", 32'(cyc - cur_gnt_at), cur.we ? 32'd1 : 32'(MEM_LAT + 1));
        if (!cur.we) model_rd[cur.port] = cur.rdata;
        check("cpu_rdata at done", 32'(cpu_rdata), 32'(model_rd[0]));
        check("dma_rdata at done", 32'(dma_rdata), 32'(model_rd[1]));
        check("busy at done", 32'(busy), 32'd1);
        last_done_at = cyc;
        cur_v = 1'b0;
      end
    end

    if (rst) begin
      exp_q.delete();
      cur_v       = 1'b0;
      model_rd[0] = 8'h00;
      model_rd[1] = 8'h00;
    end
  end

  // Requester model: drive one request, hold it until the grant, then
  // present the next one immediately or drop req.
  task automatic set_port(input int port, input logic req, input stim_t s);
    if (port == 0) begin
      cpu_req = req; cpu_we = s.we; cpu_addr = s.addr; cpu_wdata = s.wdata;
    end else begin
      dma_req = req; dma_we = s.we; dma_addr = s.addr; dma_wdata = s.wdata;
    end
  endtask

  task automatic drive_port(input int port);
    stim_t s;
    bit    got;
    bit    more;
    more = (port == 0) ? (cpu_stim.size() != 0) : (dma_stim.size() != 0);
    while (more) begin
      if (port == 0) s = cpu_stim.pop_front();
      else           s = dma_stim.pop_front();
      set_port(port, 1'b1, s);
      got = 1'b0;
      for (int i = 0; i < TIMEOUT && !got; i++) begin
        @(negedge clk);
        got = (port == 0) ? cpu_gnt : dma_gnt;
      end
      check((port == 0) ? "cpu grant within bound" : "dma grant within bound", 32'(got), 32'd1);
      @(posedge clk);
      #1;
      more = got && ((port == 0) ? (cpu_stim.size() != 0) : (dma_stim.size() != 0));
    end
    s = '{we: 1'b0, addr: '0, wdata: '0};
    set_port(port, 1'b0, s);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < TIMEOUT && !ok; i++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && !cur_v;
    end
    check("all expected accesses completed", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int port, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                              input int gnt_cyc);
    mk = '{port: port, we: we, addr: addr, wdata: wdata, rdata: rdata, gnt_cyc: gnt_cyc};
  endfunction

  function automatic stim_t st(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    st = '{we: we, addr: addr, wdata: wdata};
  endfunction

  initial begin
    int n;
    @(posedge clk);
    #1;

    // Reset held with both ports requesting; CPU wins the first tie after release.
    cpu_stim.push_back(st(1'b0, 5'h0A, 8'h00));
    dma_stim.push_back(st(1'b1, 5'h07, 8'h3C));
    fork
      drive_port(0);
      drive_port(1);
      begin
        repeat (2) begin
          @(negedge clk);
          check("outputs during reset",
                32'({cpu_gnt, dma_gnt, cpu_done, dma_done, mem_en, mem_we, mem_addr, mem_wdata, busy}),
                32'd0);
          check("cpu_rdata during reset", 32'(cpu_rdata), 32'd0);
          check("dma_rdata during reset", 32'(dma_rdata), 32'd0);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(mk(0, 1'b0, 5'h0A, 8'h00, 8'h5C, cyc + 1));
        exp_q.push_back(mk(1, 1'b1, 5'h07, 8'h3C, 8'h00, -1));
        rst = 1'b0;
      end
    join
    drain();

    // Isolated DMA write; busy drops the cycle after done.
    n = cyc;
    exp_q.push_back(mk(1, 1'b1, 5'h1F, 8'hA5, 8'h00, n + 1));
    dma_stim.push_back(st(1'b1, 5'h1F, 8'hA5));
    drive_port(1);
    while (cyc < n + 3) @(posedge clk);
    @(negedge clk);
    check("busy after write", 32'(busy), 32'd0);
    drain();

    // Both ports request continuously, 4 reads each: strict alternation.
    n = cyc;
    for (int i = 0; i < 4; i++) begin
      cpu_stim.push_back(st(1'b0, 5'(5'h01 + i), 8'h00));
      dma_stim.push_back(st(1'b0, 5'(5'h11 + i), 8'h00));
    end
    exp_q.push_back(mk(0, 1'b0, 5'h01, 8'h00, 8'hC1, n + 1));
    exp_q.push_back(mk(1, 1'b0, 5'h11, 8'h00, 8'hD1, -1));
    exp_q.push_back(mk(0, 1'b0, 5'h02, 8'h00, 8'hC2, -1));
    exp_q.push_back(mk(1, 1'b0, 5'h12, 8'h00, 8'hD2, -1));
    exp_q.push_back(mk(0, 1'b0, 5'h03, 8'h00, 8'hC3, -1));
    exp_q.push_back(mk(1, 1'b0, 5'h13, 8'h00, 8'hD3, -1));
    exp_q.push_back(mk(0, 1'b0, 5'h04, 8'h00, 8'hC4, -1));
    exp_q.push_back(mk(1, 1'b0, 5'h14, 8'h00, 8'hD4, -1));
    fork
      drive_port(0);
      drive_port(1);
    join
    drain();

    // CPU alone: three back-to-back writes, then a read of the DMA-written word.
    n = cyc;
    cpu_stim.push_back(st(1'b1, 5'h15, 8'h61));
    cpu_stim.push_back(st(1'b1, 5'h16, 8'h62));
    cpu_stim.push_back(st(1'b1, 5'h17, 8'h63));
    cpu_stim.push_back(st(1'b0, 5'h1F, 8'h00));
    exp_q.push_back(mk(0, 1'b1, 5'h15, 8'h61, 8'h00, n + 1));
    exp_q.push_back(mk(0, 1'b1, 5'h16, 8'h62, 8'h00, -1));
    exp_q.push_back(mk(0, 1'b1, 5'h17, 8'h63, 8'h00, -1));
    exp_q.push_back(mk(0, 1'b0, 5'h1F, 8'h00, 8'hA5, -1));
    drive_port(0);
    drain();

    // Reset in the second WAIT cycle of a CPU read abandons it.
    n = cyc;
    cpu_stim.push_back(st(1'b0, 5'h02, 8'h00));
    exp_q.push_back(mk(0, 1'b0, 5'h02, 8'h00, 8'hC2, n + 1));
    drive_port(0);
    while (cyc < n + 3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("cpu_rdata after abandoned read", 32'(cpu_rdata), 32'd0);
    check("busy after abandoned read", 32'(busy), 32'd0);
    check("cpu_done after abandoned read", 32'(cpu_done), 32'd0);
    @(posedge clk);
    #1;

    // Fresh DMA read after the reset is granted one cycle after the request.
    n = cyc;
    dma_stim.push_back(st(1'b0, 5'h0A, 8'h00));
    exp_q.push_back(mk(1, 1'b0, 5'h0A, 8'h00, 8'h5C, n + 1));
    drive_port(1);
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
